// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with programmable wait states and access error flagging
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_cen_D,
  input  logic        mem_wen_D,
  input  logic [29:0] mem_addr_D,
  input  logic [63:0] mem_wdata_D,
  output logic [63:0] mem_rdata_D,
  output logic        mem_stall_D,
  output logic        mem_ready_D,
  output logic        mem_err_D
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be in 1..255");
  end
  if (ADDR_W < 1 || ADDR_W > 28) begin : g_bad_addr_w
    $error("dmem_responder: ADDR_W must be in 1..28");
  end
  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              wen_q;
  logic [29:0]       addr_q;
  logic [63:0]       wdata_q;
  logic [63:0]       rdata_q;
  logic              err_q;
  logic [63:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              bad;
  logic              fire;
  // mem_addr_D[0] is byte-address bit 2; bits above the array are the out-of-range field
  assign idx  = addr_q[ADDR_W:1];
  assign bad  = addr_q[0] | (|addr_q[29:ADDR_W+1]);
  assign fire = state_q == BUSY && cnt_q == 8'd0;
  assign mem_rdata_D = rdata_q;
  // next state, wait counter and handshake outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    state_d     = state_q == IDLE ? (mem_cen_D ? BUSY : IDLE) :
                  state_q == BUSY ? (cnt_q == 8'd0 ? DONE : BUSY) : IDLE;
    cnt_d       = state_q == IDLE ? 8'(LATENCY - 1) :
                  (state_q == BUSY && cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
    mem_stall_D = rst_n & (state_q == IDLE ? mem_cen_D : state_q == BUSY);
    mem_ready_D = state_q == DONE;
    mem_err_D   = state_q == DONE && err_q;
  end
  // state, load data and error flag; the access itself happens on the last BUSY edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fire) err_q <= bad;
      if (fire && !wen_q) rdata_q <= bad ? 64'd0 : mem[idx];
    end
  end
  // request capture; only meaningful once a request is accepted in IDLE
  always_ff @(posedge clk) begin
    if (state_q == IDLE && mem_cen_D) begin
      wen_q   <= mem_wen_D;
      addr_q  <= mem_addr_D;
      wdata_q <= mem_wdata_D;
    end
  end
  // array write; not reset, and a reset on the access edge abandons the store
  always_ff @(posedge clk) begin
    if (rst_n && fire && wen_q && !bad) mem[idx] <= wdata_q;
  end
endmodule
